rfa_grant_decoder: RTL and testbench
====================================

// Module: rfa_grant_decoder
// PURPOSE
//  Reverse side of the RFA priority encoder. Accepts a winning 4-bit client index
//  from arbitration and expands it into a registered one-hot grant vector. Holds the
//  grant for a fixed number of access cycles, then emits a one-hot completion pulse.
//  Sits between the arbiter select logic and the requesting clients.
// PARAMETERS
//  NUM_CLIENTS  16  number of clients / grant bits (2..16)
//  IDX_W        4   width of sel_idx
//  HOLD_CYCLES  2   cycles each grant is held (>=1)
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous reset, active-low (0 = reset)
//  sel_valid    in   1            sel_idx valid this cycle
//  sel_idx      in   IDX_W        index of client to grant
//  sel_ready    out  1            decoder can accept sel_idx this cycle
//  grant        out  NUM_CLIENTS  registered one-hot grant, 0 when idle
//  grant_idx    out  IDX_W        binary index of current grant, 0 when idle
//  busy         out  1            grant currently held (== |grant)
//  grant_done   out  NUM_CLIENTS  one-cycle one-hot pulse, grant just released
//  err_idx      out  1            one-cycle pulse, accepted sel_idx >= NUM_CLIENTS
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE; grant, grant_idx, grant_done, err_idx,
//    hold counter all 0. sel_ready combinationally forced 0 while rst=0.
//  - FSM states: IDLE, HOLD. busy = (state==HOLD).
//  - sel_ready = rst & (IDLE | (HOLD & cnt==0)). Accept = sel_valid & sel_ready.
//  - sel_valid with sel_ready=0 is ignored; no internal queueing. Caller holds request.
//  - Accept with sel_idx < NUM_CLIENTS at edge N:
//    - grant = 1<<sel_idx and grant_idx = sel_idx from cycle N+1.
//    - cnt = HOLD_CYCLES-1; state -> HOLD.
//  - Accept with sel_idx >= NUM_CLIENTS: err_idx=1 for the next cycle only.
//    No grant; state and cnt unchanged.
//  - HOLD, cnt!=0: cnt decrements each edge; grant stable.
//  - HOLD, cnt==0 (last grant cycle), at the edge:
//    - grant_done = grant for exactly one cycle.
//    - With a valid accept: grant switches directly to the new one-hot, cnt reloads,
//      stays HOLD.
//    - Otherwise grant = 0, grant_idx = 0, state -> IDLE.
//  - Consequences:
//    - Each grant is visible exactly HOLD_CYCLES cycles.
//    - grant_done trails the last grant cycle by 1.
//    - Back-to-back grants have zero idle gap. grant_done may coincide with a new grant.
//  - Same index back-to-back: grant bit stays high continuously; grant_done pulses
//    once per completed hold.
//  - Invalid index in the last HOLD cycle: err_idx pulses, current grant completes,
//    state -> IDLE.
//  - Reset mid-HOLD: grant drops next cycle, no grant_done pulse. Pending work is lost.
//  - Invariants: grant and grant_done each zero or one-hot. grant_done never overlaps
//    the bit being newly granted, except the same-index case.
//  - Widths: sel_idx compared unsigned against NUM_CLIENTS. The one-hot shift is
//    evaluated at NUM_CLIENTS width.
// TESTING
//  1. rst=0 for 3 cycles, sel_valid=1, sel_idx=5 -> sel_ready=0, grant=0, busy=0,
//     grant_done=0 throughout. First accept occurs after rst=1.
//  2. HOLD_CYCLES=2, accept idx 5 at edge 0 -> grant=16'h0020, busy=1 in cycles 1-2;
//     grant_done=16'h0020 in cycle 3; grant=0 in cycle 3.
//  3. HOLD_CYCLES=2, accept idx 3 then idx 12 held valid -> grant=16'h0008 cycles 1-2,
//     16'h1000 cycles 3-4; grant_done=16'h0008 cycle 3, 16'h1000 cycle 5.
//  4. HOLD_CYCLES=2, idx 7 accepted twice back-to-back -> grant=16'h0080 cycles 1-4
//     continuous; grant_done=16'h0080 in cycles 3 and 5.
//  5. NUM_CLIENTS=12, accept idx 13 -> err_idx=1 one cycle, grant=0, sel_ready stays 1.
//     Then idx 11 -> grant=12'h800.
//  6. HOLD_CYCLES=1, sel_valid=1 each cycle idx 0,1,2,... -> grant walks one-hot per
//     cycle, sel_ready constantly 1. Then rst=0 mid-stream -> grant=0 next cycle,
//     no extra grant_done.

Source files
------------

// File: rtl/rfa_grant_decoder.sv
// Expands an arbitration winner index into a registered one-hot grant that is held
// for HOLD_CYCLES cycles and then retired with a one-cycle one-hot completion pulse.
module rfa_grant_decoder #(
    parameter int NUM_CLIENTS = 16,
    parameter int IDX_W       = 4,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sel_valid,
    input  logic [IDX_W-1:0]       sel_idx,
    output logic                   sel_ready,
    output logic [NUM_CLIENTS-1:0] grant,
    output logic [IDX_W-1:0]       grant_idx,
    output logic                   busy,
    output logic [NUM_CLIENTS-1:0] grant_done,
    output logic                   err_idx
);

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t                 state_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [NUM_CLIENTS-1:0] grant_reg;
    logic [IDX_W-1:0]       grant_idx_reg;
    logic [NUM_CLIENTS-1:0] grant_done_reg;
    logic                   err_idx_reg;

    logic [NUM_CLIENTS-1:0] sel_onehot;
    logic                   idx_in_range;
    logic                   last_cycle;
    logic                   accept;
    logic                   accept_ok;
    logic                   accept_bad;

    // Out-of-range indices decode to all zeros, which doubles as the range check.
    for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_dec
        assign sel_onehot[gi] = (32'(sel_idx) == gi);
    end

    assign idx_in_range = |sel_onehot;
    assign last_cycle   = (state_reg == HOLD) && (cnt_reg == '0);
    assign sel_ready    = rst && ((state_reg == IDLE) || last_cycle);
    assign accept       = sel_valid && sel_ready;
    assign accept_ok    = accept && idx_in_range;
    assign accept_bad   = accept && !idx_in_range;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            grant_reg      <= '0;
            grant_idx_reg  <= '0;
            grant_done_reg <= '0;
            err_idx_reg    <= 1'b0;
        end else begin
            grant_done_reg <= '0;
            err_idx_reg    <= accept_bad;
            case (state_reg)
                IDLE: begin
                    if (accept_ok) begin
                        grant_reg     <= sel_onehot;
                        grant_idx_reg <= sel_idx;
                        cnt_reg       <= CNT_RELOAD;
                        state_reg     <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - CNT_W'(1);
                    end else begin
                        // Last grant cycle: retire it, and chain straight into a new one if offered.
                        grant_done_reg <= grant_reg;
                        if (accept_ok) begin
                            grant_reg     <= sel_onehot;
                            grant_idx_reg <= sel_idx;
                            cnt_reg       <= CNT_RELOAD;
                        end else begin
                            grant_reg     <= '0;
                            grant_idx_reg <= '0;
                            state_reg     <= IDLE;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign grant      = grant_reg;
    assign grant_idx  = grant_idx_reg;
    assign busy       = (state_reg == HOLD);
    assign grant_done = grant_done_reg;
    assign err_idx    = err_idx_reg;

    a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
    a_done_onehot0  : assert property (@(posedge clk) disable iff (!rst) $onehot0(grant_done));
    a_busy_matches  : assert property (@(posedge clk) disable iff (!rst) busy == (|grant));

endmodule

// File: tb/tb_rfa_grant_decoder.sv
// Bench for rfa_grant_decoder: several parameterisations share one stimulus stream,
// each with its own reference model, expectation queue and monitor.
module tb_rfa_grant_decoder;

    localparam int NCFG = 4;

    typedef struct {
        logic        ready;
        logic [15:0] grant;
        logic [15:0] gidx;
        logic        busy;
        logic [15:0] done;
        logic        err;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       sel_valid;
    logic [3:0] sel_idx;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input int cfg, input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL cfg%0d %s t=%0t actual=%h expected=%h", cfg, name, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int NC = (gi == 1) ? 12 : ((gi == 3) ? 10 : 16);
        localparam int HC = (gi == 2) ? 1 : ((gi == 3) ? 3 : 2);

        logic          sel_ready;
        logic [NC-1:0] grant;
        logic [3:0]    grant_idx;
        logic          busy;
        logic [NC-1:0] grant_done;
        logic          err_idx;
        exp_t          q[$];

        rfa_grant_decoder #(
            .NUM_CLIENTS(NC),
            .IDX_W      (4),
            .HOLD_CYCLES(HC)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .sel_valid (sel_valid),
            .sel_idx   (sel_idx),
            .sel_ready (sel_ready),
            .grant     (grant),
            .grant_idx (grant_idx),
            .busy      (busy),
            .grant_done(grant_done),
            .err_idx   (err_idx)
        );

        // Model: "remaining" counts how many more cycles the current grant stays visible.
        initial begin : model
            int          rem;
            int          cur;
            int          idx;
            bit          acc;
            bit          rdy;
            logic [15:0] done_now;
            logic        err_now;
            exp_t        e;
            rem      = 0;
            cur      = 0;
            done_now = '0;
            err_now  = 1'b0;
            forever begin
                @(negedge clk);
                #1;
                rdy     = (rst === 1'b1) && (rem <= 1);
                e.ready = rdy;
                e.busy  = (rem > 0);
                e.grant = (rem > 0) ? 16'(1 << cur) : 16'h0;
                e.gidx  = (rem > 0) ? 16'(cur) : 16'h0;
                e.done  = done_now;
                e.err   = err_now;
                q.push_back(e);
                if (rst !== 1'b1) begin
                    rem      = 0;
                    done_now = '0;
                    err_now  = 1'b0;
                end else begin
                    acc      = (sel_valid === 1'b1) && rdy;
                    idx      = int'(sel_idx);
                    done_now = (rem == 1) ? 16'(1 << cur) : 16'h0;
                    err_now  = acc && (idx >= NC);
                    if (acc && idx < NC) begin
                        cur = idx;
                        rem = HC;
                    end else if (rem > 0) begin
                        rem--;
                    end
                end
            end
        end

        initial begin : monitor
            exp_t e;
            forever begin
                @(negedge clk);
                #2;
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL cfg%0d queue_empty t=%0t actual=0 expected=1", gi, $time);
                end else begin
                    e = q.pop_front();
                    chk(gi, "sel_ready",  16'(sel_ready),  16'(e.ready));
                    chk(gi, "grant",      16'(grant),      e.grant);
                    chk(gi, "grant_idx",  16'(grant_idx),  e.gidx);
                    chk(gi, "busy",       16'(busy),       16'(e.busy));
                    chk(gi, "grant_done", 16'(grant_done), e.done);
                    chk(gi, "err_idx",    16'(err_idx),    16'(e.err));
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic v, input int i);
        @(negedge clk);
        rst       = r;
        sel_valid = v;
        sel_idx   = 4'(i);
    endtask

    initial begin
        rst       = 1'b0;
        sel_valid = 1'b1;
        sel_idx   = 4'd5;
        repeat (3) cyc(1'b0, 1'b1, 5);
        // Single grant, then idle.
        cyc(1'b1, 1'b1, 5);
        repeat (3) cyc(1'b1, 1'b0, 0);
        // Two different indices back to back, second held until accepted.
        cyc(1'b1, 1'b1, 3);
        repeat (3) cyc(1'b1, 1'b1, 12);
        repeat (3) cyc(1'b1, 1'b0, 0);
        // Same index twice back to back.
        repeat (4) cyc(1'b1, 1'b1, 7);
        repeat (3) cyc(1'b1, 1'b0, 0);
        // Out-of-range index, then the top legal index.
        cyc(1'b1, 1'b1, 13);
        cyc(1'b1, 1'b1, 11);
        repeat (3) cyc(1'b1, 1'b0, 0);
        // Walking stream with a reset landing mid-grant.
        for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, i);
        cyc(1'b0, 1'b1, 8);
        cyc(1'b1, 1'b0, 0);
        for (int i = 9; i < 16; i++) cyc(1'b1, 1'b1, i);
        repeat (3) cyc(1'b1, 1'b0, 0);
        // Randomised traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 59) != 0), ($urandom_range(0, 9) < 7),
                int'($urandom_range(0, 15)));
        end
        repeat (5) cyc(1'b1, 1'b0, 0);
        @(negedge clk);
        #5;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
